// File: rtl/mu0_ctrl_pkg.sv
// Shared constants and types for the MU0 control unit: opcodes, ALU modes,
// state encodings and the control vector handed to the datapath.
package mu0_ctrl_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STO = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    localparam logic [1:0] M_PASSY = 2'b00;
    localparam logic [1:0] M_ADD   = 2'b01;
    localparam logic [1:0] M_INC   = 2'b10;
    localparam logic [1:0] M_SUB   = 2'b11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] m;
        logic       xsel;
        logic       ysel;
        logic       asel;
        logic       pcen;
        logic       iren;
        logic       accen;
        logic       rd;
        logic       wr;
    } ctrl_t;

    // LDA/STO/ADD/SUB touch memory in EXEC and must wait for mem_ready.
    function automatic logic isMemOp(input logic [3:0] opcode);
        return (opcode[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/mu0_ctrl_if.sv
// Control-unit bundle between mu0_ctrl and the datapath/memory side:
// status inputs (ir, acc, mem_ready) and every select/enable/strobe.
interface mu0_ctrl_if #(
    parameter int MAXWIDTH = 16
);
    logic [MAXWIDTH-1:0] ir;
    logic [MAXWIDTH-1:0] acc;
    logic                mem_ready;
    logic [1:0]          M;
    logic                Xsel;
    logic                Ysel;
    logic                Asel;
    logic                PCen;
    logic                IRen;
    logic                ACCen;
    logic                Rd;
    logic                Wr;

    modport master (
        input  ir, acc, mem_ready,
        output M, Xsel, Ysel, Asel, PCen, IRen, ACCen, Rd, Wr
    );

    modport slave (
        output ir, acc, mem_ready,
        input  M, Xsel, Ysel, Asel, PCen, IRen, ACCen, Rd, Wr
    );
endinterface

// File: rtl/mu0_ctrl_decode.sv
// Purely combinational decoder: (state, opcode, acc flags, mem_ready) to the
// full control vector. Anything not used by the active state/opcode stays 0.
module mu0_ctrl_decode
    import mu0_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic       accNeg,
    input  logic       accZero,
    input  logic       memReady,
    input  logic       active,
    output ctrl_t      ctrl
);

    // Register enables follow mem_ready so wait cycles never load anything.
    always_comb begin
        ctrl = '0;
        if (active) begin
            unique case (state)
                S_FETCH: begin
                    ctrl.rd   = 1'b1;
                    ctrl.m    = M_INC;
                    ctrl.iren = memReady;
                    ctrl.pcen = memReady;
                end
                S_EXEC: begin
                    unique case (opcode)
                        OP_LDA: begin
                            ctrl.asel  = 1'b1;
                            ctrl.rd    = 1'b1;
                            ctrl.ysel  = 1'b1;
                            ctrl.m     = M_PASSY;
                            ctrl.accen = memReady;
                        end
                        OP_STO: begin
                            ctrl.asel = 1'b1;
                            ctrl.wr   = 1'b1;
                            ctrl.xsel = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl.asel  = 1'b1;
                            ctrl.rd    = 1'b1;
                            ctrl.xsel  = 1'b1;
                            ctrl.ysel  = 1'b1;
                            ctrl.m     = (opcode == OP_ADD) ? M_ADD : M_SUB;
                            ctrl.accen = memReady;
                        end
                        OP_JMP: ctrl.pcen = 1'b1;
                        OP_JGE: ctrl.pcen = ~accNeg;
                        OP_JNE: ctrl.pcen = ~accZero;
                        default: ctrl = '0;
                    endcase
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/mu0_ctrl.sv
// MU0 fetch/execute control unit: state register, retired-instruction
// counter and halt flag; control outputs come straight from the decoder.
module mu0_ctrl
    import mu0_ctrl_pkg::*;
#(
    parameter int MAXWIDTH = 16,
    parameter int CNTWIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    mu0_ctrl_if.master          bus,
    output logic                halted,
    output logic [CNTWIDTH-1:0] instr_count
);

    state_t     state;
    ctrl_t      ctrl;
    logic [3:0] opcode;
    logic       execDone;

    assign opcode   = bus.ir[15:12];
    assign execDone = (state == S_EXEC) && (!isMemOp(opcode) || bus.mem_ready);

    // Gating on reset keeps every output at 0 while reset is held, even
    // though the reset state itself is FETCH.
    mu0_ctrl_decode u_decode (
        .state    (state),
        .opcode   (opcode),
        .accNeg   (bus.acc[MAXWIDTH-1]),
        .accZero  (bus.acc == '0),
        .memReady (bus.mem_ready),
        .active   (~reset),
        .ctrl     (ctrl)
    );

    assign bus.M     = ctrl.m;
    assign bus.Xsel  = ctrl.xsel;
    assign bus.Ysel  = ctrl.ysel;
    assign bus.Asel  = ctrl.asel;
    assign bus.PCen  = ctrl.pcen;
    assign bus.IRen  = ctrl.iren;
    assign bus.ACCen = ctrl.accen;
    assign bus.Rd    = ctrl.rd;
    assign bus.Wr    = ctrl.wr;

    // Every exit from EXEC retires one instruction, STP and NOPs included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FETCH;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (bus.mem_ready) state <= S_EXEC;
                end
                S_EXEC: begin
                    if (execDone) begin
                        instr_count <= instr_count + CNTWIDTH'(1);
                        if (opcode == OP_STP) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mu0_ctrl.sv
// Directed bench for mu0_ctrl: table of EXEC decode vectors plus hand-written
// sequences for reset, back-to-back issue, memory waits, halt and wrap.
module tb_mu0_ctrl;

    localparam int CW = 8;
    // {M, Xsel Ysel Asel, PCen IRen ACCen, Rd Wr}
    localparam logic [9:0] FETCH_RDY  = 10'b10_000_110_10;
    localparam logic [9:0] FETCH_WAIT = 10'b10_000_000_10;
    localparam logic [9:0] ALL_ZERO   = 10'b00_000_000_00;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] acc;
        logic        ready;
        logic [9:0]  expVec;
        logic [7:0]  expCount;
        logic        expHalt;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          halted;
    logic [CW-1:0] instrCount;
    int            checks = 0;
    int            passes = 0;
    vec_t          vecs[14];

    mu0_ctrl_if #(.MAXWIDTH(16)) bus ();

    mu0_ctrl #(.MAXWIDTH(16), .CNTWIDTH(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .halted      (halted),
        .instr_count (instrCount)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [9:0] getVec();
        return {bus.M, bus.Xsel, bus.Ysel, bus.Asel, bus.PCen, bus.IRen,
                bus.ACCen, bus.Rd, bus.Wr};
    endfunction

    task automatic applyStimulus(input logic [15:0] ir, input logic [15:0] acc,
                                 input logic ready);
        bus.ir        = ir;
        bus.acc       = acc;
        bus.mem_ready = ready;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [9:0] expVec);
        logic [9:0] got;
        got = getVec();
        checks++;
        if (got === expVec) passes++;
        else $display("[TB] FAIL %s: got %b want %b", name, got, expVec);
    endtask

    task automatic checkValue(input string name, input logic [15:0] got,
                              input logic [15:0] want);
        checks++;
        if (got === want) passes++;
        else $display("[TB] FAIL %s: got %h want %h", name, got, want);
    endtask

    // Ends at a negedge with reset just released and state FETCH.
    task automatic doReset(input bit doCheck);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(16'h0000, 16'h0000, 1'b1);
        if (doCheck) begin
            checkOutput("resetOutputs", ALL_ZERO);
            checkValue("resetCount", 16'(instrCount), 16'h0000);
            checkValue("resetHalted", 16'(halted), 16'h0000);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{16'h0123, 16'h0000, 1'b1, 10'b00_011_001_10, 8'd1, 1'b0};
        vecs[1]  = '{16'h0123, 16'h0000, 1'b0, 10'b00_011_000_10, 8'd0, 1'b0};
        vecs[2]  = '{16'h1456, 16'h0000, 1'b1, 10'b00_101_000_01, 8'd1, 1'b0};
        vecs[3]  = '{16'h1456, 16'h0000, 1'b0, 10'b00_101_000_01, 8'd0, 1'b0};
        vecs[4]  = '{16'h2123, 16'h0000, 1'b1, 10'b01_111_001_10, 8'd1, 1'b0};
        vecs[5]  = '{16'h3123, 16'h0000, 1'b1, 10'b11_111_001_10, 8'd1, 1'b0};
        vecs[6]  = '{16'h4010, 16'h0000, 1'b0, 10'b00_000_100_00, 8'd1, 1'b0};
        vecs[7]  = '{16'h5010, 16'h8000, 1'b1, 10'b00_000_000_00, 8'd1, 1'b0};
        vecs[8]  = '{16'h5010, 16'h0001, 1'b1, 10'b00_000_100_00, 8'd1, 1'b0};
        vecs[9]  = '{16'h6010, 16'h0000, 1'b1, 10'b00_000_000_00, 8'd1, 1'b0};
        vecs[10] = '{16'h6010, 16'h0005, 1'b0, 10'b00_000_100_00, 8'd1, 1'b0};
        vecs[11] = '{16'h7000, 16'h1234, 1'b1, 10'b00_000_000_00, 8'd1, 1'b1};
        vecs[12] = '{16'hF000, 16'h0000, 1'b1, 10'b00_000_000_00, 8'd1, 1'b0};
        vecs[13] = '{16'h8ABC, 16'hFFFF, 1'b0, 10'b00_000_000_00, 8'd1, 1'b0};

        bus.ir = '0;
        bus.acc = '0;
        bus.mem_ready = 1'b0;

        // Reset, then one fetch and one EXEC cycle per table row.
        doReset(1'b1);
        for (int i = 0; i < 14; i++) begin
            if (i != 0) doReset(1'b0);
            applyStimulus(16'h0000, 16'h0000, 1'b1);
            checkOutput($sformatf("fetch[%0d]", i), FETCH_RDY);
            @(negedge clk);
            applyStimulus(vecs[i].ir, vecs[i].acc, vecs[i].ready);
            checkOutput($sformatf("exec[%0d]", i), vecs[i].expVec);
            @(negedge clk);
            applyStimulus(16'h0000, 16'h0000, 1'b0);
            checkValue($sformatf("count[%0d]", i), 16'(instrCount), 16'(vecs[i].expCount));
            checkValue($sformatf("halt[%0d]", i), 16'(halted), 16'(vecs[i].expHalt));
        end

        // ADD then STO back to back with memory always ready.
        doReset(1'b0);
        applyStimulus(16'h2123, 16'h0000, 1'b1);
        checkOutput("addFetch", FETCH_RDY);
        @(negedge clk);
        applyStimulus(16'h2123, 16'h0000, 1'b1);
        checkOutput("addExec", 10'b01_111_001_10);
        @(negedge clk);
        applyStimulus(16'h1456, 16'h0000, 1'b1);
        checkOutput("stoFetch", FETCH_RDY);
        @(negedge clk);
        applyStimulus(16'h1456, 16'h0000, 1'b1);
        checkOutput("stoExec", 10'b00_101_000_01);
        @(negedge clk);
        applyStimulus(16'h1456, 16'h0000, 1'b0);
        checkValue("twoInstrCount", 16'(instrCount), 16'h0002);

        // Fetch waits three cycles, then LDA waits and is aborted by reset.
        doReset(1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h0123, 16'h0000, 1'b0);
            checkOutput($sformatf("fetchWait[%0d]", i), FETCH_WAIT);
            @(negedge clk);
        end
        applyStimulus(16'h0123, 16'h0000, 1'b1);
        checkOutput("fetchReady", FETCH_RDY);
        @(negedge clk);
        applyStimulus(16'h0123, 16'h0000, 1'b0);
        checkOutput("ldaWait", 10'b00_011_000_10);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(16'h0123, 16'h0000, 1'b1);
        checkOutput("ldaAbort", ALL_ZERO);
        @(negedge clk);
        applyStimulus(16'h0123, 16'h0000, 1'b1);
        checkOutput("ldaAbortHeld", ALL_ZERO);
        checkValue("abortCount", 16'(instrCount), 16'h0000);
        reset = 1'b0;
        applyStimulus(16'h0123, 16'h0000, 1'b0);
        checkOutput("abortToFetch", FETCH_WAIT);

        // STP halts for good regardless of mem_ready.
        doReset(1'b0);
        applyStimulus(16'h7000, 16'h0000, 1'b1);
        @(negedge clk);
        applyStimulus(16'h7000, 16'h0000, 1'b1);
        checkOutput("stpExec", ALL_ZERO);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus(16'h0123, 16'h0000, 1'(i % 2));
            checkOutput($sformatf("haltOut[%0d]", i), ALL_ZERO);
            checkValue($sformatf("haltFlag[%0d]", i), 16'(halted), 16'h0001);
        end
        checkValue("haltCount", 16'(instrCount), 16'h0001);

        // Counter wraps after 2^CW NOPs.
        doReset(1'b0);
        applyStimulus(16'hF000, 16'h0000, 1'b1);
        repeat (2 * 255) @(negedge clk);
        checkValue("countFull", 16'(instrCount), 16'h00FF);
        repeat (2) @(negedge clk);
        checkValue("countWrap", 16'(instrCount), 16'h0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
